// File: rtl/branch_exec_unit_pkg.sv
// Shared types for the branch execution unit: instruction class and compare op.
package branch_exec_unit_pkg;

    // Instruction class presented by the branch reservation station.
    typedef enum logic [1:0] {
        ITYPE_BRANCH = 2'd0,
        ITYPE_JAL    = 2'd1,
        ITYPE_JALR   = 2'd2,
        ITYPE_NONE   = 2'd3
    } inst_type_t;

    // Conditional branch compare op, encoded like the RISC-V funct3 field.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_op_t;

    // Byte distance to the sequential next instruction.
    localparam int INST_BYTES = 4;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch resolution: condition, target, link, mispredict, misalign.
module branch_resolve
    import branch_exec_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  inst_type_t        inst_type,
    input  branch_op_t        branch_op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    output logic [XLEN-1:0]   target,
    output logic [XLEN-1:0]   link,
    output logic              mispredict,
    output logic              misalign
);

    logic            cond;
    logic            taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;

    assign pc_plus4    = pc + XLEN'(INST_BYTES);
    assign pc_plus_imm = pc + imm;
    assign jalr_sum    = rs1 + imm;

    // Evaluate the compare op; undefined op encodings never take.
    always_comb begin
        // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
        cond = 1'b0;
        case (branch_op)
            BR_BEQ:  cond = (rs1 == rs2);
            BR_BNE:  cond = (rs1 != rs2);
            BR_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            BR_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            BR_BLTU: cond = (rs1 <  rs2);
            BR_BGEU: cond = (rs1 >= rs2);
            default: cond = 1'b0;
        endcase
    end

    // Pick direction, resolved next PC and link value from the instruction class.
    always_comb begin
        taken  = 1'b0;
        target = pc_plus4;
        link   = '0;
        case (inst_type)
            ITYPE_BRANCH: begin
                taken = cond;
                if (cond) target = pc_plus_imm;
            end
            ITYPE_JAL: begin
                taken  = 1'b1;
                target = pc_plus_imm;
                link   = pc_plus4;
            end
            ITYPE_JALR: begin
                taken  = 1'b1;
                target = jalr_sum & ~XLEN'(1);
                link   = pc_plus4;
            end
            default: ;
        endcase
    end

    // A taken op must also match the predicted target to count as correct.
    assign mispredict = (taken != pred_taken) || (taken && (target != pred_target));
    assign misalign   = taken && target[1];

endmodule

// File: rtl/branch_exec_unit.sv
// Pipelined branch execution unit: resolve, hold, return on CDB, redirect, count.
module branch_exec_unit
    import branch_exec_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [TAG_W-1:0]  issue_tag,
    input  inst_type_t        issue_inst_type,
    input  branch_op_t        issue_branch_op,
    input  logic [XLEN-1:0]   issue_rs1,
    input  logic [XLEN-1:0]   issue_rs2,
    input  logic [XLEN-1:0]   issue_pc,
    input  logic [XLEN-1:0]   issue_imm,
    input  logic              issue_pred_taken,
    input  logic [XLEN-1:0]   issue_pred_target,
    output logic              cdb_valid,
    input  logic              cdb_ready,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [XLEN-1:0]   cdb_data,
    output logic              cdb_misalign,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [TAG_W-1:0]  redirect_tag,
    output logic [CNT_W-1:0]  stat_resolved,
    output logic [CNT_W-1:0]  stat_mispred
);

    // Stage payload. The taken bit is already folded into target (resolved
    // next PC), mispredict and misalign, so it is not carried down the pipe.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  link;
        logic             mispredict;
        logic             misalign;
    } brx_entry_t;

    brx_entry_t      resolved;
    brx_entry_t      s1_entry;
    brx_entry_t      out_entry;
    logic            s1_valid;
    logic            s1_load;
    logic            out_valid;
    logic            issue_fire;
    logic            completion;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_link;
    logic            r_mispredict;
    logic            r_misalign;

    branch_resolve #(.XLEN(XLEN)) u_resolve (
        .inst_type   (issue_inst_type),
        .branch_op   (issue_branch_op),
        .rs1         (issue_rs1),
        .rs2         (issue_rs2),
        .pc          (issue_pc),
        .imm         (issue_imm),
        .pred_taken  (issue_pred_taken),
        .pred_target (issue_pred_target),
        .target      (r_target),
        .link        (r_link),
        .mispredict  (r_mispredict),
        .misalign    (r_misalign)
    );

    assign resolved = '{tag: issue_tag, target: r_target, link: r_link,
                        mispredict: r_mispredict, misalign: r_misalign};

    // Reset gates issue_ready so every output reads 0 while rst_n is low.
    assign issue_ready = rst_n && !flush && s1_load;
    assign issue_fire  = issue_valid && issue_ready;
    assign completion  = out_valid && cdb_ready;

    // Stage 1 captures the resolved op; flush drops it at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            // NOTE: payload registers are reset as well so all outputs read 0 in reset, not just the valid bits.
            s1_entry <= '0;
        end else begin
            if (flush)        s1_valid <= 1'b0;
            else if (s1_load) s1_valid <= issue_valid;
            if (issue_fire)   s1_entry <= resolved;
        end
    end

    generate
        if (STAGES == 1) begin : g_one_stage
            assign s1_load   = !s1_valid || cdb_ready;
            assign out_valid = s1_valid;
            assign out_entry = s1_entry;
        end else if (STAGES == 2) begin : g_two_stage
            logic       s2_valid;
            logic       s2_load;
            brx_entry_t s2_entry;

            assign s2_load   = !s2_valid || cdb_ready;
            assign s1_load   = !s1_valid || s2_load;
            assign out_valid = s2_valid;
            assign out_entry = s2_entry;

            // Stage 2 is a pure holding register in front of the CDB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_entry <= '0;
                end else begin
                    if (flush)        s2_valid <= 1'b0;
                    else if (s2_load) s2_valid <= s1_valid;
                    if (s2_load && s1_valid) s2_entry <= s1_entry;
                end
            end
        end else begin : g_bad_stages
            $error("branch_exec_unit: STAGES must be 1 or 2");
        end
    endgenerate

    assign cdb_valid      = out_valid;
    assign cdb_tag        = out_entry.tag;
    assign cdb_data       = out_entry.link;
    assign cdb_misalign   = out_entry.misalign;
    assign redirect_valid = completion && out_entry.mispredict && !flush;
    assign redirect_pc    = out_entry.target;
    assign redirect_tag   = out_entry.tag;

    // Saturating statistics, bumped on every completed CDB handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else if (completion) begin
            if (stat_resolved != '1) stat_resolved <= stat_resolved + CNT_W'(1);
            if (out_entry.mispredict && (stat_mispred != '1))
                stat_mispred <= stat_mispred + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_exec_unit.sv
// Directed self-checking bench for branch_exec_unit (vector table plus corner sequences).
module tb_branch_exec_unit;
    import branch_exec_unit_pkg::*;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 6;
    localparam int STAGES = 2;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              issue_valid = 1'b0;
    logic              cdb_ready = 1'b1;
    logic [TAG_W-1:0]  issue_tag = '0;
    inst_type_t        issue_inst_type = ITYPE_BRANCH;
    branch_op_t        issue_branch_op = BR_BEQ;
    logic [XLEN-1:0]   issue_rs1 = '0, issue_rs2 = '0, issue_pc = '0, issue_imm = '0;
    logic              issue_pred_taken = 1'b0;
    logic [XLEN-1:0]   issue_pred_target = '0;

    logic              issue_ready, cdb_valid, cdb_misalign, redirect_valid;
    logic [TAG_W-1:0]  cdb_tag, redirect_tag;
    logic [XLEN-1:0]   cdb_data, redirect_pc;
    logic [CNT_W-1:0]  stat_resolved, stat_mispred;

    logic              sat_issue_ready, sat_cdb_valid, sat_cdb_misalign, sat_redirect_valid;
    logic [TAG_W-1:0]  sat_cdb_tag, sat_redirect_tag;
    logic [XLEN-1:0]   sat_cdb_data, sat_redirect_pc;
    logic [1:0]        sat_stat_resolved, sat_stat_mispred;

    logic              s1_issue_ready, s1_cdb_valid, s1_cdb_misalign, s1_redirect_valid;
    logic [TAG_W-1:0]  s1_cdb_tag, s1_redirect_tag;
    logic [XLEN-1:0]   s1_cdb_data, s1_redirect_pc;
    logic [CNT_W-1:0]  s1_stat_resolved, s1_stat_mispred;

    always #5 clk = ~clk;

    branch_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_inst_type(issue_inst_type), .issue_branch_op(issue_branch_op),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_pred_taken(issue_pred_taken), .issue_pred_target(issue_pred_target),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_misalign(cdb_misalign), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_tag(redirect_tag), .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
    );

    // Same stimulus, 2-bit counters: exercises saturation.
    branch_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(sat_issue_ready), .issue_tag(issue_tag),
        .issue_inst_type(issue_inst_type), .issue_branch_op(issue_branch_op),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_pred_taken(issue_pred_taken), .issue_pred_target(issue_pred_target),
        .cdb_valid(sat_cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(sat_cdb_tag), .cdb_data(sat_cdb_data),
        .cdb_misalign(sat_cdb_misalign), .redirect_valid(sat_redirect_valid), .redirect_pc(sat_redirect_pc),
        .redirect_tag(sat_redirect_tag), .stat_resolved(sat_stat_resolved), .stat_mispred(sat_stat_mispred)
    );

    // Single-stage variant: latency one cycle shorter.
    branch_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(1), .CNT_W(CNT_W)) u_s1 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(s1_issue_ready), .issue_tag(issue_tag),
        .issue_inst_type(issue_inst_type), .issue_branch_op(issue_branch_op),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .issue_pred_taken(issue_pred_taken), .issue_pred_target(issue_pred_target),
        .cdb_valid(s1_cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(s1_cdb_tag), .cdb_data(s1_cdb_data),
        .cdb_misalign(s1_cdb_misalign), .redirect_valid(s1_redirect_valid), .redirect_pc(s1_redirect_pc),
        .redirect_tag(s1_redirect_tag), .stat_resolved(s1_stat_resolved), .stat_mispred(s1_stat_mispred)
    );

    typedef struct {
        inst_type_t  itype;
        branch_op_t  op;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [31:0] exp_data;
        logic        exp_redirect;
        logic [31:0] exp_next_pc;
        logic        exp_misalign;
    } vec_t;

    vec_t vecs[12];
    vec_t bp[4];
    vec_t fx, fy, fz, rv;

    int checks = 0;
    int failures = 0;
    int exp_res = 0;
    int exp_mis = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic drive_op(input vec_t v, input logic [TAG_W-1:0] tag);
        issue_valid       = 1'b1;
        issue_tag         = tag;
        issue_inst_type   = v.itype;
        issue_branch_op   = v.op;
        issue_rs1         = v.rs1;
        issue_rs2         = v.rs2;
        issue_pc          = v.pc;
        issue_imm         = v.imm;
        issue_pred_taken  = v.pred_taken;
        issue_pred_target = v.pred_target;
    endtask

    task automatic check_counters(input string name);
        check({name, "_stat_resolved"}, stat_resolved, exp_res);
        check({name, "_stat_mispred"}, stat_mispred, exp_mis);
        check({name, "_sat_resolved"}, sat_stat_resolved, sat3(exp_res));
        check({name, "_sat_mispred"}, sat_stat_mispred, sat3(exp_mis));
    endtask

    // One op from idle with cdb_ready=1: latency, payload, one-cycle redirect, counters.
    task automatic run_vec(input int idx);
        vec_t v;
        int   n;
        logic [TAG_W-1:0] tag;
        v   = vecs[idx];
        tag = TAG_W'(idx + 1);
        @(negedge clk);
        cdb_ready = 1'b1;
        drive_op(v, tag);
        #1;
        check("vec_issue_ready", issue_ready, 1'b1);
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            issue_valid = 1'b0;
            #1;
            n++;
            if (n == 1) begin
                check("vec_s1_cdb_valid", s1_cdb_valid, 1'b1);
                check("vec_s1_cdb_data", s1_cdb_data, v.exp_data);
            end
            if (!cdb_valid) check("vec_no_early_redirect", redirect_valid, 1'b0);
        end while (!cdb_valid && n < 8);
        check("vec_latency", n, STAGES);
        check("vec_cdb_tag", cdb_tag, tag);
        check("vec_cdb_data", cdb_data, v.exp_data);
        check("vec_cdb_misalign", cdb_misalign, v.exp_misalign);
        check("vec_redirect_valid", redirect_valid, v.exp_redirect);
        check("vec_redirect_pc", redirect_pc, v.exp_next_pc);
        if (v.exp_redirect) check("vec_redirect_tag", redirect_tag, tag);
        exp_res++;
        if (v.exp_redirect) exp_mis++;
        @(negedge clk);
        #1;
        check("vec_cdb_valid_after", cdb_valid, 1'b0);
        check("vec_redirect_one_cycle", redirect_valid, 1'b0);
        check_counters("vec");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TAG_W-1:0] got[$];
        logic             held;
        logic             fire;
        logic [TAG_W-1:0] h_tag;
        logic [XLEN-1:0]  h_data, h_pc;
        logic             exp_ready[6];
        int               acc;
        int               k;

        // itype, op, rs1, rs2, pc, imm, pred_taken, pred_target, exp_data, exp_redirect, exp_next_pc, exp_misalign
        vecs[0]  = '{ITYPE_BRANCH, BR_BEQ,  32'd5,        32'd5,        32'h100,      32'h20,       1'b1, 32'h120,  32'h0,   1'b0, 32'h120,  1'b0};
        vecs[1]  = '{ITYPE_BRANCH, BR_BLT,  32'hFFFFFFFF, 32'd1,        32'h200,      32'h10,       1'b0, 32'h0,    32'h0,   1'b1, 32'h210,  1'b0};
        vecs[2]  = '{ITYPE_BRANCH, BR_BLTU, 32'hFFFFFFFF, 32'd1,        32'h200,      32'h10,       1'b0, 32'h0,    32'h0,   1'b0, 32'h204,  1'b0};
        vecs[3]  = '{ITYPE_JALR,   BR_BEQ,  32'h1003,     32'd0,        32'h40,       32'h0,        1'b1, 32'h1002, 32'h44,  1'b0, 32'h1002, 1'b1};
        vecs[4]  = '{ITYPE_BRANCH, BR_BNE,  32'd3,        32'd3,        32'h300,      32'h40,       1'b1, 32'h340,  32'h0,   1'b1, 32'h304,  1'b0};
        vecs[5]  = '{ITYPE_BRANCH, BR_BGE,  32'h80000000, 32'h7FFFFFFF, 32'h400,      32'hFFFFFFF0, 1'b1, 32'h3F0,  32'h0,   1'b1, 32'h404,  1'b0};
        vecs[6]  = '{ITYPE_BRANCH, BR_BGEU, 32'h80000000, 32'h7FFFFFFF, 32'h400,      32'hFFFFFFF0, 1'b1, 32'h3F0,  32'h0,   1'b0, 32'h3F0,  1'b0};
        vecs[7]  = '{ITYPE_JAL,    BR_BEQ,  32'd0,        32'd0,        32'h500,      32'h102,      1'b1, 32'h602,  32'h504, 1'b0, 32'h602,  1'b1};
        vecs[8]  = '{ITYPE_JAL,    BR_BEQ,  32'd0,        32'd0,        32'hFFFFFFFC, 32'h8,        1'b1, 32'h0,    32'h0,   1'b1, 32'h4,    1'b0};
        vecs[9]  = '{ITYPE_BRANCH, BR_BEQ,  32'd1,        32'd2,        32'h600,      32'h20,       1'b0, 32'h0,    32'h0,   1'b0, 32'h604,  1'b0};
        vecs[10] = '{ITYPE_NONE,   BR_BEQ,  32'd0,        32'd0,        32'h700,      32'h10,       1'b1, 32'h700,  32'h0,   1'b1, 32'h704,  1'b0};
        vecs[11] = '{ITYPE_BRANCH, BR_BLT,  32'd7,        32'd7,        32'h720,      32'h10,       1'b0, 32'h0,    32'h0,   1'b0, 32'h724,  1'b0};

        bp[0] = '{ITYPE_BRANCH, BR_BEQ, 32'd1, 32'd1, 32'h800, 32'h10,  1'b0, 32'h0,   32'h0,   1'b1, 32'h810, 1'b0};
        bp[1] = '{ITYPE_BRANCH, BR_BNE, 32'd1, 32'd2, 32'h810, 32'h20,  1'b1, 32'h830, 32'h0,   1'b0, 32'h830, 1'b0};
        bp[2] = '{ITYPE_BRANCH, BR_BNE, 32'd1, 32'd1, 32'h820, 32'h20,  1'b1, 32'h840, 32'h0,   1'b1, 32'h824, 1'b0};
        bp[3] = '{ITYPE_JAL,    BR_BEQ, 32'd0, 32'd0, 32'h830, 32'h100, 1'b1, 32'h930, 32'h834, 1'b0, 32'h930, 1'b0};

        fx = '{ITYPE_BRANCH, BR_BEQ, 32'd4, 32'd4, 32'hA00, 32'h40, 1'b0, 32'h0,   32'h0,   1'b1, 32'hA40, 1'b0};
        fy = '{ITYPE_JAL,    BR_BEQ, 32'd0, 32'd0, 32'hA10, 32'h8,  1'b1, 32'hA18, 32'hA14, 1'b0, 32'hA18, 1'b0};
        fz = '{ITYPE_JAL,    BR_BEQ, 32'd0, 32'd0, 32'hA20, 32'h8,  1'b0, 32'h0,   32'hA24, 1'b1, 32'hA28, 1'b0};
        rv = '{ITYPE_JAL,    BR_BEQ, 32'd0, 32'd0, 32'hB00, 32'h10, 1'b1, 32'hB10, 32'hB04, 1'b0, 32'hB10, 1'b0};

        exp_ready = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state.
        #1;
        check("rst_issue_ready", issue_ready, 1'b0);
        check("rst_cdb_valid", cdb_valid, 1'b0);
        check("rst_redirect_valid", redirect_valid, 1'b0);
        check_counters("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_issue_ready", issue_ready, 1'b1);

        // Vector table.
        for (int i = 0; i < 12; i++) run_vec(i);

        // Backpressure: four back-to-back issues, cdb_ready low for the first four cycles.
        acc  = 0;
        held = 1'b0;
        h_tag = '0; h_data = '0; h_pc = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            cdb_ready = (c >= 4);
            if (acc < 4) drive_op(bp[acc], TAG_W'(32 + acc));
            else issue_valid = 1'b0;
            #1;
            if (c < 6) check("bp_issue_ready", issue_ready, exp_ready[c]);
            fire = issue_valid && issue_ready;
            if (cdb_valid) begin
                if (held) begin
                    check("bp_stable_tag", cdb_tag, h_tag);
                    check("bp_stable_data", cdb_data, h_data);
                    check("bp_stable_pc", redirect_pc, h_pc);
                end
                if (!cdb_ready) begin
                    check("bp_held_no_redirect", redirect_valid, 1'b0);
                    held = 1'b1; h_tag = cdb_tag; h_data = cdb_data; h_pc = redirect_pc;
                end else begin
                    k = got.size();
                    if (k < 4) begin
                        check("bp_redirect_valid", redirect_valid, bp[k].exp_redirect);
                        check("bp_next_pc", redirect_pc, bp[k].exp_next_pc);
                        check("bp_cdb_data", cdb_data, bp[k].exp_data);
                        exp_res++;
                        if (bp[k].exp_redirect) exp_mis++;
                    end
                    got.push_back(cdb_tag);
                    held = 1'b0;
                end
            end
            @(posedge clk);
            if (fire) acc++;
        end
        check("bp_accepted", acc, 4);
        check("bp_completed", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("bp_order", got[i], 32 + i);
        @(negedge clk);
        #1;
        check_counters("bp");

        // Flush with two ops in flight and an issue request; the output op completes in the flush cycle.
        cdb_ready = 1'b0;
        @(negedge clk); drive_op(fx, TAG_W'(48));
        @(posedge clk);
        @(negedge clk); drive_op(fy, TAG_W'(49));
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        cdb_ready = 1'b1;
        drive_op(fz, TAG_W'(50));
        #1;
        check("fl_issue_ready", issue_ready, 1'b0);
        check("fl_cdb_valid", cdb_valid, 1'b1);
        check("fl_cdb_tag", cdb_tag, 48);
        check("fl_redirect_masked", redirect_valid, 1'b0);
        exp_res++;
        exp_mis++;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        issue_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("fl_no_cdb_valid", cdb_valid, 1'b0);
            check("fl_no_redirect", redirect_valid, 1'b0);
            @(negedge clk);
        end
        #1;
        check("fl_issue_ready_back", issue_ready, 1'b1);
        check_counters("fl");

        // Asynchronous reset mid-operation with a held result.
        @(negedge clk);
        cdb_ready = 1'b0;
        drive_op(rv, TAG_W'(63));
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
        @(negedge clk);
        #1;
        check("rs_pre_cdb_valid", cdb_valid, 1'b1);
        check("rs_pre_cdb_data", cdb_data, rv.exp_data);
        #2;
        rst_n = 1'b0;
        exp_res = 0;
        exp_mis = 0;
        #1;
        check("rs_cdb_valid", cdb_valid, 1'b0);
        check("rs_cdb_tag", cdb_tag, 0);
        check("rs_cdb_data", cdb_data, 0);
        check("rs_cdb_misalign", cdb_misalign, 1'b0);
        check("rs_redirect_valid", redirect_valid, 1'b0);
        check("rs_redirect_pc", redirect_pc, 0);
        check("rs_redirect_tag", redirect_tag, 0);
        check("rs_issue_ready", issue_ready, 1'b0);
        check_counters("rs");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rs_release_issue_ready", issue_ready, 1'b1);
        check("rs_release_cdb_valid", cdb_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
